// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-stage FSM encoding and bus timeout default.
package mips_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;
  localparam int unsigned WAIT_CNT_W          = 8;

endpackage

// File: rtl/mem_stage.sv
// MIPS memory stage: passes ALU results to writeback and runs one data-memory
// request at a time, with misalignment and ack-timeout detection.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_target,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        bus_error
);

  localparam logic [WAIT_CNT_W:0] TIMEOUT_C = (WAIT_CNT_W + 1)'(TIMEOUT);

  mem_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_CNT_W:0]   cnt_inc;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [4:0]            dest_q, dest_d;
  logic                  regw_q, regw_d;
  logic                  we_q, we_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_regw_q, wb_regw_d;
  logic [4:0]            wb_dest_q, wb_dest_d;
  logic [31:0]           wb_data_q, wb_data_d;
  logic                  berr_q, berr_d;
  logic                  pc_src_q, pc_src_d;
  logic [31:0]           pc_tgt_q, pc_tgt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
      regw_q     <= 1'b0;
      we_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_regw_q  <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      berr_q     <= 1'b0;
      pc_src_q   <= 1'b0;
      pc_tgt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dest_q     <= dest_d;
      regw_q     <= regw_d;
      we_q       <= we_d;
      wb_valid_q <= wb_valid_d;
      wb_regw_q  <= wb_regw_d;
      wb_dest_q  <= wb_dest_d;
      wb_data_q  <= wb_data_d;
      berr_q     <= berr_d;
      pc_src_q   <= pc_src_d;
      pc_tgt_q   <= pc_tgt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cnt_inc    = {1'b0, cnt_q} + 1'b1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dest_d     = dest_q;
    regw_d     = regw_q;
    we_d       = we_q;
    wb_valid_d = 1'b0;
    wb_regw_d  = wb_regw_q;
    wb_dest_d  = wb_dest_q;
    wb_data_d  = wb_data_q;
    berr_d     = berr_q;
    pc_src_d   = 1'b0;
    pc_tgt_d   = pc_tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (branch && zero) begin
            pc_src_d = 1'b1;
            pc_tgt_d = branch_target;
          end
          if (mem_read || mem_write) begin
            if (alu_result[1:0] != 2'b00) begin
              // Misaligned: retire immediately as a non-writing error instead of touching memory.
              wb_valid_d = 1'b1;
              wb_regw_d  = 1'b0;
              wb_dest_d  = dest_reg;
              wb_data_d  = alu_result;
              berr_d     = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = '0;
              addr_d  = alu_result;
              wdata_d = store_data;
              dest_d  = dest_reg;
              regw_d  = reg_write;
              we_d    = ~mem_read;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_regw_d  = reg_write;
            wb_dest_d  = dest_reg;
            wb_data_d  = alu_result;
          end
        end
      end
      ST_WAIT: begin
        // Ack is checked before the timeout so a last-cycle ack still completes normally.
        if (dm_ack) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_dest_d  = dest_q;
          wb_regw_d  = we_q ? 1'b0 : regw_q;
          wb_data_d  = we_q ? addr_q : dm_rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d    = ST_IDLE;
          cnt_d      = cnt_inc[WAIT_CNT_W-1:0];
          wb_valid_d = 1'b1;
          wb_regw_d  = 1'b0;
          wb_dest_d  = dest_q;
          wb_data_d  = addr_q;
          berr_d     = 1'b1;
        end else begin
          cnt_d = cnt_inc[WAIT_CNT_W-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall        = (state_q == ST_WAIT);
  assign dm_req       = (state_q == ST_WAIT);
  assign dm_we        = we_q;
  assign dm_addr      = addr_q;
  assign dm_wdata     = wdata_q;
  assign pc_src       = pc_src_q;
  assign pc_target    = pc_tgt_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_regw_q;
  assign wb_dest      = wb_dest_q;
  assign wb_data      = wb_data_q;
  assign bus_error    = berr_q;

endmodule
